ring_tap_ctl: RTL and testbench

- Control core of a bridge ring tap; sits between the registered ring/port input stages and the registered ring/port output stages.
- Steers ring-in packets to the local TX port and/or onward around the ring, based on the header destination mask.
- Injects local RX packets onto the ring, stamped with the FIB lookup result.
- Shares ring-out between through traffic and local traffic with packet-granular arbitration.

---
 rtl/ring_tap_pkg.sv | 37 +++
 rtl/ring_tap_ctl_arb.sv | 46 ++++
 rtl/ring_tap_ctl.sv | 165 ++++++++++++++++
 tb/tb_ring_tap_ctl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_tap_pkg.sv
// Shared definitions for the bridge ring tap: port count, word framing codes and FSM state encodings.
package ring_tap_pkg;

  localparam int NUM_PORTS = 4;

  // pcode field sits in data[width-PCODE_HI : width-PCODE_LO] (offsets below the word width)
  localparam int PCODE_HI = 1;
  localparam int PCODE_LO = 2;

  localparam logic [1:0] PC_MOP  = 2'b00;
  localparam logic [1:0] PC_SOP  = 2'b01;
  localparam logic [1:0] PC_EOP  = 2'b10;
  localparam logic [1:0] PC_SEOP = 2'b11;

  typedef logic [0:0] ri_state_t;
  localparam ri_state_t RI_IDLE = 1'b0;
  localparam ri_state_t RI_PKT  = 1'b1;

  typedef logic [1:0] px_state_t;
  localparam px_state_t PX_IDLE = 2'd0;
  localparam px_state_t PX_PKT  = 2'd1;
  localparam px_state_t PX_DROP = 2'd2;

  typedef logic [1:0] grant_t;
  localparam grant_t GR_NONE = 2'b00;
  localparam grant_t GR_RING = 2'b01;
  localparam grant_t GR_PORT = 2'b10;

  function automatic logic is_sop(input logic [1:0] pc);
    return pc[0];
  endfunction

  function automatic logic is_eop(input logic [1:0] pc);
    return pc[1];
  endfunction

endpackage

// File: rtl/ring_tap_ctl_arb.sv
// ring_pkt_arb: two-requester round-robin arbiter whose grant is held from SOP to EOP transfer.
module ring_pkt_arb
  import ring_tap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       sop,
  input  logic       eop_xfer,
  output logic [1:0] grant
);

  logic   locked;
  grant_t owner;
  grant_t ptr;

  always_comb begin
    grant = GR_NONE;
    if (locked) begin
      grant = owner;
    end else begin
      unique case (req)
        2'b01:   grant = GR_RING;
        2'b10:   grant = GR_PORT;
        2'b11:   grant = ptr;
        default: grant = GR_NONE;
      endcase
    end
  end

  // After a packet completes, priority passes to the requester that did not just send.
  always_ff @(posedge clk) begin
    if (!reset) begin
      locked <= 1'b0;
      owner  <= GR_NONE;
      ptr    <= GR_RING;
    end else if (eop_xfer) begin
      locked <= 1'b0;
      ptr    <= (grant == GR_RING) ? GR_PORT : GR_RING;
    end else if (sop) begin
      locked <= 1'b1;
      owner  <= grant;
    end
  end

endmodule

// File: rtl/ring_tap_ctl.sv
// Ring tap control core: steers ring traffic to port/ring and injects port RX traffic onto the ring.
// Optional saturating packet counters are built when RING_TAP_STATS_EN is defined.
module ring_tap_ctl
  import ring_tap_pkg::*;
#(
  parameter int rdp_sz  = 64,
  parameter int portnum = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ri_srdy,
  output logic                 ri_drdy,
  input  logic [rdp_sz-1:0]    ri_data,
  input  logic                 prx_srdy,
  output logic                 prx_drdy,
  input  logic [rdp_sz-1:0]    prx_data,
  input  logic                 fli_srdy,
  output logic                 fli_drdy,
  input  logic [NUM_PORTS-1:0] fli_data,
  output logic                 ro_srdy,
  input  logic                 ro_drdy,
  output logic [rdp_sz-1:0]    ro_data,
  output logic                 ptx_srdy,
  input  logic                 ptx_drdy,
  output logic [rdp_sz-1:0]    ptx_data
`ifdef RING_TAP_STATS_EN
  ,
  output logic [15:0]          stat_ring_drop,
  output logic [15:0]          stat_port_drop,
  output logic [15:0]          stat_ptx_pkts
`endif
);

  localparam logic [NUM_PORTS-1:0] SELF = NUM_PORTS'(1) << portnum;

  ri_state_t            ri_state;
  px_state_t            px_state;
  logic                 to_ptx_q, to_ro_q;
  logic [1:0]           ri_pc, px_pc, ro_pc;
  logic                 ri_head, ri_live, to_ptx, to_ro, ri_ok;
  logic                 px_head;
  logic [NUM_PORTS-1:0] eff;
  logic                 ring_req, port_req;
  logic [1:0]           grant;
  logic                 ro_ring_ok, ro_port_ok, ro_xfer;

  assign ri_pc = ri_data[rdp_sz-PCODE_HI:rdp_sz-PCODE_LO];
  assign px_pc = prx_data[rdp_sz-PCODE_HI:rdp_sz-PCODE_LO];
  assign ro_pc = ro_data[rdp_sz-PCODE_HI:rdp_sz-PCODE_LO];

  // Outside a packet, only an SOP starts one; any other word is junk and gets sunk.
  assign ri_head = (ri_state == RI_IDLE) & is_sop(ri_pc);
  assign ri_live = (ri_state == RI_PKT) | ri_head;
  assign to_ptx  = ri_head ? ri_data[portnum] : to_ptx_q;
  assign to_ro   = ri_head ? |(ri_data[NUM_PORTS-1:0] & ~SELF) : to_ro_q;

  assign px_head = (px_state == PX_IDLE) & is_sop(px_pc);
  assign eff     = fli_data & ~SELF;

  assign ring_req = ri_srdy & ri_live & to_ro;
  assign port_req = prx_srdy & ((px_head & fli_srdy & (eff != '0)) | (px_state == PX_PKT));

  ring_pkt_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({port_req, ring_req}),
    .sop      (ro_xfer & is_sop(ro_pc)),
    .eop_xfer (ro_xfer & is_eop(ro_pc)),
    .grant    (grant)
  );

  assign ro_ring_ok = (grant == GR_RING) & ro_drdy;
  assign ro_port_ok = (grant == GR_PORT) & ro_drdy;
  assign ri_ok      = (!to_ptx | ptx_drdy) & (!to_ro | ro_ring_ok);
  assign ro_xfer    = ro_srdy & ro_drdy;
  assign ptx_data   = ri_data;

  always_comb begin
    ri_drdy  = 1'b0;
    prx_drdy = 1'b0;
    fli_drdy = 1'b0;
    ro_srdy  = 1'b0;
    ptx_srdy = 1'b0;
    if (reset) begin
      // Each ring output waits for the other selected output so both copies move together.
      ri_drdy  = ri_live ? ri_ok : 1'b1;
      ptx_srdy = ri_srdy & ri_live & to_ptx & (!to_ro | ro_ring_ok);
      ro_srdy  = ri_srdy & ri_live & to_ro & (grant == GR_RING) & (!to_ptx | ptx_drdy);
      unique case (px_state)
        PX_IDLE: begin
          if (px_head) begin
            if (fli_srdy && eff != '0) begin
              ro_srdy  = ro_srdy | (prx_srdy & (grant == GR_PORT));
              prx_drdy = ro_port_ok;
            end else begin
              prx_drdy = fli_srdy;
            end
            fli_drdy = prx_srdy & prx_drdy;
          end else begin
            prx_drdy = 1'b1;
          end
        end
        PX_PKT: begin
          ro_srdy  = ro_srdy | (prx_srdy & (grant == GR_PORT));
          prx_drdy = ro_port_ok;
        end
        default: prx_drdy = 1'b1;
      endcase
    end
  end

  always_comb begin
    ro_data = ri_data;
    if (ri_head) ro_data[NUM_PORTS-1:0] = ri_data[NUM_PORTS-1:0] & ~SELF;
    if (grant == GR_PORT) begin
      ro_data = prx_data;
      if (px_head) ro_data[NUM_PORTS-1:0] = eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ri_state <= RI_IDLE;
      to_ptx_q <= 1'b0;
      to_ro_q  <= 1'b0;
    end else if (ri_srdy && ri_drdy && ri_live) begin
      ri_state <= is_eop(ri_pc) ? RI_IDLE : RI_PKT;
      to_ptx_q <= to_ptx;
      to_ro_q  <= to_ro;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      px_state <= PX_IDLE;
    end else if (prx_srdy && prx_drdy) begin
      unique case (px_state)
        PX_IDLE: if (px_head && !is_eop(px_pc)) px_state <= (eff != '0) ? PX_PKT : PX_DROP;
        default: if (is_eop(px_pc)) px_state <= PX_IDLE;
      endcase
    end
  end

`ifdef RING_TAP_STATS_EN
  logic ring_drop_evt, port_drop_evt, ptx_evt;

  assign ring_drop_evt = ri_srdy & ri_drdy & ri_live & is_eop(ri_pc) & !to_ptx & !to_ro;
  assign port_drop_evt = prx_srdy & prx_drdy & is_eop(px_pc) &
                         ((px_state == PX_DROP) | (px_head & (eff == '0)));
  assign ptx_evt       = ptx_srdy & ptx_drdy & is_eop(ri_pc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_ring_drop <= '0;
      stat_port_drop <= '0;
      stat_ptx_pkts  <= '0;
    end else begin
      if (ring_drop_evt && stat_ring_drop != '1) stat_ring_drop <= stat_ring_drop + 16'd1;
      if (port_drop_evt && stat_port_drop != '1) stat_port_drop <= stat_port_drop + 16'd1;
      if (ptx_evt && stat_ptx_pkts != '1) stat_ptx_pkts <= stat_ptx_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_tap_ctl.sv
// Bench for ring_tap_ctl (portnum=1): directed vector table, corner sequences and random traffic vs a packet-level model.
module tb_ring_tap_ctl;
  import ring_tap_pkg::*;

  localparam int W  = 64;
  localparam int PN = 1;

  logic         clk, reset;
  logic         ri_srdy, ri_drdy, prx_srdy, prx_drdy, fli_srdy, fli_drdy;
  logic         ro_srdy, ro_drdy, ptx_srdy, ptx_drdy;
  logic [W-1:0] ri_data, prx_data, ro_data, ptx_data;
  logic [3:0]   fli_data;
`ifdef RING_TAP_STATS_EN
  logic [15:0]  stat_ring_drop, stat_port_drop, stat_ptx_pkts;
`endif

  ring_tap_ctl #(.rdp_sz(W), .portnum(PN)) dut (
    .clk(clk), .reset(reset),
    .ri_srdy(ri_srdy), .ri_drdy(ri_drdy), .ri_data(ri_data),
    .prx_srdy(prx_srdy), .prx_drdy(prx_drdy), .prx_data(prx_data),
    .fli_srdy(fli_srdy), .fli_drdy(fli_drdy), .fli_data(fli_data),
    .ro_srdy(ro_srdy), .ro_drdy(ro_drdy), .ro_data(ro_data),
    .ptx_srdy(ptx_srdy), .ptx_drdy(ptx_drdy), .ptx_data(ptx_data)
`ifdef RING_TAP_STATS_EN
    , .stat_ring_drop(stat_ring_drop), .stat_port_drop(stat_port_drop), .stat_ptx_pkts(stat_ptx_pkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned seq = 0;

  typedef struct {
    logic rst; logic ri_v; logic [W-1:0] ri_d; logic px_v; logic [W-1:0] px_d;
    logic fl_v; logic [3:0] fl_d; logic ro_r; logic ptx_r;
    logic e_ri; logic e_px; logic e_fl; logic e_ro; logic e_ptx;
    logic [W-1:0] e_ro_d; logic [W-1:0] e_ptx_d;
  } vec_t;
  vec_t tbl[$];

  logic [W-1:0] exp_ptx[$], exp_ro_r[$], exp_ro_p[$], ri_q[$], px_q[$];
  logic [3:0]   fli_q[$];
  int           ro_order[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] pc, input logic [15:0] pay, input logic [3:0] m);
    return {pc, 42'd0, pay, m};
  endfunction

  function automatic vec_t row(input logic rst, ri_v, input logic [W-1:0] ri_d, input logic px_v,
                               input logic [W-1:0] px_d, input logic fl_v, input logic [3:0] fl_d,
                               input logic ro_r, ptx_r, e_ri, e_px, e_fl, e_ro, e_ptx,
                               input logic [W-1:0] e_ro_d, e_ptx_d);
    vec_t v;
    v.rst = rst; v.ri_v = ri_v; v.ri_d = ri_d; v.px_v = px_v; v.px_d = px_d;
    v.fl_v = fl_v; v.fl_d = fl_d; v.ro_r = ro_r; v.ptx_r = ptx_r;
    v.e_ri = e_ri; v.e_px = e_px; v.e_fl = e_fl; v.e_ro = e_ro; v.e_ptx = e_ptx;
    v.e_ro_d = e_ro_d; v.e_ptx_d = e_ptx_d;
    return v;
  endfunction

  task automatic drive(input logic ri_v, input logic [W-1:0] ri_d, input logic px_v, input logic [W-1:0] px_d,
                       input logic fl_v, input logic [3:0] fl_d, input logic ro_r, input logic ptx_r);
    ri_srdy = ri_v; ri_data = ri_d; prx_srdy = px_v; prx_data = px_d;
    fli_srdy = fl_v; fli_data = fl_d; ro_drdy = ro_r; ptx_drdy = ptx_r;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, '0, 0, '0, 0, '0, 1, 1);
    next_cyc(); next_cyc();
    reset = 1'b1;
  endtask

  // Packet-level model: destinations and rewritten SOP masks follow directly from the header rules.
  task automatic gen_ring(input logic [3:0] m, input int unsigned len);
    logic [1:0] pc;
    logic [W-1:0] w;
    logic [3:0] fwd;
    fwd = m & ~(4'b0001 << PN);
    for (int unsigned i = 0; i < len; i++) begin
      pc = (len == 1) ? PC_SEOP : (i == 0) ? PC_SOP : (i == len - 1) ? PC_EOP : PC_MOP;
      w  = mk(pc, {1'b0, 15'(seq)}, (i == 0) ? m : 4'($urandom));
      seq++;
      ri_q.push_back(w);
      if (m[PN]) exp_ptx.push_back(w);
      if (fwd != 4'd0) exp_ro_r.push_back((i == 0) ? {w[W-1:4], fwd} : w);
    end
  endtask

  task automatic gen_port(input logic [3:0] f, input int unsigned len);
    logic [1:0] pc;
    logic [W-1:0] w;
    logic [3:0] eff;
    eff = f & ~(4'b0001 << PN);
    fli_q.push_back(f);
    for (int unsigned i = 0; i < len; i++) begin
      pc = (len == 1) ? PC_SEOP : (i == 0) ? PC_SOP : (i == len - 1) ? PC_EOP : PC_MOP;
      w  = mk(pc, {1'b1, 15'(seq)}, 4'($urandom));
      seq++;
      px_q.push_back(w);
      if (eff != 4'd0) exp_ro_p.push_back((i == 0) ? {w[W-1:4], eff} : w);
    end
  endtask

  task automatic run_traffic(input int unsigned pct, input int unsigned budget);
    int src;
    int s;
    int unsigned cyc;
    src = -1;
    cyc = 0;
    while ((ri_q.size() + px_q.size() + exp_ptx.size() + exp_ro_r.size() + exp_ro_p.size()) != 0 && cyc < budget) begin
      drive(ri_q.size() != 0 && $urandom_range(99) < pct, (ri_q.size() != 0) ? ri_q[0] : '0,
            px_q.size() != 0 && $urandom_range(99) < pct, (px_q.size() != 0) ? px_q[0] : '0,
            fli_q.size() != 0 && $urandom_range(99) < pct, (fli_q.size() != 0) ? fli_q[0] : '0,
            $urandom_range(99) < pct, $urandom_range(99) < pct);
      @(negedge clk);
      if (ri_srdy && ri_drdy) void'(ri_q.pop_front());
      if (prx_srdy && prx_drdy) void'(px_q.pop_front());
      if (fli_srdy && fli_drdy) void'(fli_q.pop_front());
      if (ptx_srdy && ptx_drdy) begin
        if (exp_ptx.size() == 0) chk("ptx_extra_word", ptx_data, '0);
        else chk("ptx_word", ptx_data, exp_ptx.pop_front());
      end
      if (ro_srdy && ro_drdy) begin
        s = int'(ro_data[19]);
        if (src >= 0) chk("ro_no_interleave", W'(s), W'(src));
        if (s == 0) begin
          if (exp_ro_r.size() == 0) chk("ro_extra_ring_word", ro_data, '0);
          else chk("ro_ring_word", ro_data, exp_ro_r.pop_front());
        end else begin
          if (exp_ro_p.size() == 0) chk("ro_extra_port_word", ro_data, '0);
          else chk("ro_port_word", ro_data, exp_ro_p.pop_front());
        end
        if (is_eop(ro_data[W-1:W-2])) begin
          ro_order.push_back(s);
          src = -1;
        end else begin
          src = s;
        end
      end
      next_cyc();
      cyc++;
    end
    chk("traffic_within_budget", W'(cyc < budget), W'(1));
    chk("fli_all_consumed", W'(fli_q.size()), '0);
  endtask

  logic [W-1:0] a0, a1, a2, b0, b0r, b1, p0, p0r, p1, d0, e0, e1, z0, r0, q0, q0r, t0, m1;
  int unsigned pulses;

  initial begin
    a0 = mk(PC_SOP, 16'h0a00, 4'b0010); a1 = mk(PC_MOP, 16'h0a01, 4'b0000); a2 = mk(PC_EOP, 16'h0a02, 4'b0000);
    b0 = mk(PC_SOP, 16'h0b00, 4'b0110); b0r = mk(PC_SOP, 16'h0b00, 4'b0100); b1 = mk(PC_EOP, 16'h0b01, 4'b0011);
    p0 = mk(PC_SOP, 16'h8c00, 4'b0000); p0r = mk(PC_SOP, 16'h8c00, 4'b1001); p1 = mk(PC_EOP, 16'h8c01, 4'b0110);
    d0 = mk(PC_SEOP, 16'h8d00, 4'b1111); e0 = mk(PC_SOP, 16'h8e00, 4'b0000); e1 = mk(PC_EOP, 16'h8e01, 4'b0000);
    z0 = mk(PC_SEOP, 16'h0f00, 4'b0000); r0 = mk(PC_SEOP, 16'h0100, 4'b0100);
    q0 = mk(PC_SEOP, 16'h8200, 4'b0101); q0r = mk(PC_SEOP, 16'h8200, 4'b1000);
    t0 = mk(PC_SEOP, 16'h0300, 4'b0010); m1 = mk(PC_MOP, 16'h0b02, 4'b0110);
    reset = 1'b0;

    //                rst ri ri_d px px_d fl fl_d ro ptx | e_ri e_px e_fl e_ro e_ptx e_ro_d e_ptx_d
    tbl.push_back(row(0, 1, a0, 1, p0, 1, 4'b0001, 1, 1, 0, 0, 0, 0, 0, '0, '0));
    tbl.push_back(row(1, 1, a0, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 0, 1, '0, a0));
    tbl.push_back(row(1, 1, a1, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 0, 1, '0, a1));
    tbl.push_back(row(1, 1, a2, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 0, 1, '0, a2));
    tbl.push_back(row(1, 1, b0, 0, '0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 1, '0, b0));
    tbl.push_back(row(1, 1, b0, 0, '0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, '0, '0));
    tbl.push_back(row(1, 1, b0, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 1, b0r, b0));
    tbl.push_back(row(1, 1, b1, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 1, b1, b1));
    tbl.push_back(row(1, 0, '0, 1, p0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0, '0, '0));
    tbl.push_back(row(1, 0, '0, 1, p0, 1, 4'b1001, 1, 1, 0, 1, 1, 1, 0, p0r, '0));
    tbl.push_back(row(1, 0, '0, 1, p1, 1, 4'b1001, 1, 1, 0, 1, 0, 1, 0, p1, '0));
    tbl.push_back(row(1, 0, '0, 1, d0, 1, 4'b0010, 1, 1, 0, 1, 1, 0, 0, '0, '0));
    tbl.push_back(row(1, 0, '0, 1, e0, 1, 4'b0000, 1, 1, 0, 1, 1, 0, 0, '0, '0));
    tbl.push_back(row(1, 0, '0, 1, e1, 1, 4'b0000, 1, 1, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(row(1, 1, z0, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 0, 0, '0, '0));
    tbl.push_back(row(1, 1, r0, 1, q0, 1, 4'b1000, 1, 1, 1, 0, 0, 1, 0, r0, '0));
    tbl.push_back(row(1, 1, r0, 1, q0, 1, 4'b1000, 1, 1, 0, 1, 1, 1, 0, q0r, '0));
    tbl.push_back(row(1, 1, r0, 0, '0, 0, 4'b0000, 0, 1, 0, 0, 0, 1, 0, r0, '0));
    tbl.push_back(row(1, 1, r0, 0, '0, 0, 4'b0000, 1, 1, 1, 0, 0, 1, 0, r0, '0));
    tbl.push_back(row(1, 1, t0, 1, q0, 1, 4'b1000, 1, 1, 1, 1, 1, 1, 1, q0r, t0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      drive(tbl[i].ri_v, tbl[i].ri_d, tbl[i].px_v, tbl[i].px_d, tbl[i].fl_v, tbl[i].fl_d, tbl[i].ro_r, tbl[i].ptx_r);
      @(negedge clk);
      if (tbl[i].ri_v) chk($sformatf("v%0d_ri_drdy", i), ri_drdy, tbl[i].e_ri);
      if (tbl[i].px_v) chk($sformatf("v%0d_prx_drdy", i), prx_drdy, tbl[i].e_px);
      chk($sformatf("v%0d_fli_drdy", i), fli_drdy, tbl[i].e_fl);
      chk($sformatf("v%0d_ro_srdy", i), ro_srdy, tbl[i].e_ro);
      chk($sformatf("v%0d_ptx_srdy", i), ptx_srdy, tbl[i].e_ptx);
      if (tbl[i].e_ro) chk($sformatf("v%0d_ro_data", i), ro_data, tbl[i].e_ro_d);
      if (tbl[i].e_ptx) chk($sformatf("v%0d_ptx_data", i), ptx_data, tbl[i].e_ptx_d);
      next_cyc();
    end

    // ptx back-pressure holds the whole ring word, including its ro copy
    drive(1, b0, 0, '0, 0, '0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ri_drdy", ri_drdy, 1'b0);
      chk("stall_no_ro_xfer", ro_srdy & ro_drdy, 1'b0);
      next_cyc();
    end
    drive(1, b0, 0, '0, 0, '0, 1, 1);
    @(negedge clk);
    chk("stall_release_ri_drdy", ri_drdy, 1'b1);
    chk("stall_release_ro_data", ro_data, b0r);
    chk("stall_release_ptx_data", ptx_data, b0);
    next_cyc();
    drive(1, b1, 0, '0, 0, '0, 1, 1);
    @(negedge clk);
    chk("stall_eop_ri_drdy", ri_drdy, 1'b1);
    next_cyc();

    // late FIB result: SOP waits, fli consumed exactly once
    pulses = 0;
    drive(0, '0, 1, p0, 0, '0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fli_wait_prx_drdy", prx_drdy, 1'b0);
      if (fli_drdy) pulses++;
      next_cyc();
    end
    drive(0, '0, 1, p0, 1, 4'b1001, 1, 1);
    @(negedge clk);
    chk("fli_sop_prx_drdy", prx_drdy, 1'b1);
    chk("fli_sop_ro_data", ro_data, p0r);
    if (fli_drdy) pulses++;
    next_cyc();
    drive(0, '0, 1, p1, 1, 4'b1001, 1, 1);
    @(negedge clk);
    chk("fli_eop_prx_drdy", prx_drdy, 1'b1);
    if (fli_drdy) pulses++;
    next_cyc();
    chk("fli_drdy_pulses", W'(pulses), W'(1));

    // reset in the middle of a ring packet
    drive(1, b0, 0, '0, 0, '0, 1, 1);
    next_cyc();
    drive(1, m1, 0, '0, 0, '0, 1, 1);
    next_cyc();
    reset = 1'b0;
    drive(1, m1, 1, p0, 1, 4'b1000, 1, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("in_reset_handshakes", {ri_drdy, prx_drdy, fli_drdy, ro_srdy, ptx_srdy}, 5'b0);
      next_cyc();
    end
    reset = 1'b1;
    drive(1, m1, 0, '0, 0, '0, 1, 1);
    @(negedge clk);
    chk("junk_mop_ri_drdy", ri_drdy, 1'b1);
    chk("junk_mop_outputs", {ro_srdy, ptx_srdy}, 2'b00);
    next_cyc();
    drive(1, b1, 0, '0, 0, '0, 1, 1);
    @(negedge clk);
    chk("junk_eop_ri_drdy", ri_drdy, 1'b1);
    chk("junk_eop_outputs", {ro_srdy, ptx_srdy}, 2'b00);
    next_cyc();
    drive(1, t0, 1, e0, 1, 4'b0000, 1, 1);
    @(negedge clk);
    chk("post_reset_sop_ptx", {ptx_srdy, ro_srdy}, 2'b10);
    next_cyc();
    drive(0, '0, 1, e1, 0, '0, 1, 1);
    @(negedge clk);
    chk("post_reset_drop_sink", {prx_drdy, ro_srdy}, 2'b10);
    next_cyc();
`ifdef RING_TAP_STATS_EN
    chk("stat_port_drop", stat_port_drop, 16'd1);
    chk("stat_ptx_pkts", stat_ptx_pkts, 16'd1);
    chk("stat_ring_drop", stat_ring_drop, 16'd0);
`endif

    // saturated arbitration: whole packets alternate starting with the ring
    do_reset();
    gen_ring(4'b0100, 4); gen_ring(4'b0100, 4);
    gen_port(4'b1000, 4); gen_port(4'b1000, 4);
    ro_order.delete();
    run_traffic(100, 200);
    chk("rr_packet_count", W'(ro_order.size()), W'(4));
    for (int k = 0; k < 4; k++)
      if (k < ro_order.size()) chk($sformatf("rr_order_%0d", k), W'(ro_order[k]), W'(k % 2));

    // random traffic against the packet-level model
    do_reset();
    for (int k = 0; k < 40; k++) begin
      gen_ring(4'($urandom), $urandom_range(1, 4));
      gen_port(4'($urandom), $urandom_range(1, 4));
    end
    run_traffic(70, 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
